// File: rtl/uart_rx.sv
// UART receiver: recovers 8N1-style frames (DATA_BITS data bits, LSB first, no parity,
// one stop bit) from the asynchronous rx line and hands each byte to the consumer over a
// valid/ready handshake.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   rx_ready   consumer accepts the byte when rx_valid && rx_ready
//   rx_data    received byte, stable while rx_valid is high
//   rx_valid   byte available, held until accepted
//   frame_err  1-clk pulse: stop bit sampled low
//   overrun    1-clk pulse: good frame completed while the previous byte was still pending
//
// The oversample tick is derived locally from INITIAL_CLOCK / (BAUD * OVERSAMPLE_TIME).
// Byte, valid and error outputs are registered, so they appear 1 clk after the stop-sample
// tick.

module uart_rx #(
  parameter int unsigned INITIAL_CLOCK   = 100000000,
  parameter int unsigned BAUD            = 9600,
  parameter int unsigned OVERSAMPLE_TIME = 8,
  parameter int unsigned DATA_BITS       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun
);

  // Tick divider: counter runs 0..Div and pulses tick on Div.
  localparam int unsigned Div  = INITIAL_CLOCK / (BAUD * OVERSAMPLE_TIME) - 1;
  localparam int unsigned DivW = (Div > 0) ? $clog2(Div + 1) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(Div);

  localparam int unsigned OsW = $clog2(OVERSAMPLE_TIME);
  localparam logic [OsW-1:0] OsHalf = OsW'(OVERSAMPLE_TIME / 2 - 1);
  localparam logic [OsW-1:0] OsLast = OsW'(OVERSAMPLE_TIME - 1);

  localparam int unsigned BitW = $clog2(DATA_BITS + 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  // Input synchronizer.
  logic rx_meta_q, rx_s_q;

  // Tick generator.
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            tick;

  // Receive FSM.
  state_e               state_q, state_d;
  logic [OsW-1:0]       os_cnt_q, os_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 good_frame;
  logic                 bad_frame;

  // Output / handshake registers.
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 accept;

  // ---------------------------------------------------------------------------------------
  // Two-flop synchronizer; resets to the idle (high) line level.
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Free-running oversample tick.
  // ---------------------------------------------------------------------------------------
  assign tick = (div_cnt_q == DivMax);

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (tick) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Receive FSM: state register.
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Receive FSM: next state. Everything advances on tick except the WAIT_IDLE exit.
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    good_frame = 1'b0;
    bad_frame  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tick && !rx_s_q) begin
          state_d  = StStart;
          os_cnt_d = '0;
        end
      end

      StStart: begin
        if (tick) begin
          if (os_cnt_q == OsHalf) begin
            // Mid start bit: a high line here means the falling edge was a glitch.
            if (rx_s_q) begin
              state_d = StIdle;
            end else begin
              state_d   = StData;
              os_cnt_d  = '0;
              bit_cnt_d = '0;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end

      StData: begin
        if (tick) begin
          if (os_cnt_q == OsLast) begin
            // LSB arrives first, so shifting in at the MSB leaves it at bit 0 at the end.
            shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
            os_cnt_d  = '0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BitLast) begin
              state_d = StStop;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end

      StStop: begin
        if (tick) begin
          if (os_cnt_q == OsLast) begin
            os_cnt_d = '0;
            if (rx_s_q) begin
              good_frame = 1'b1;
              state_d    = StIdle;
            end else begin
              bad_frame = 1'b1;
              state_d   = StWaitIdle;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end

      StWaitIdle: begin
        // A held break must not be decoded as a stream of new start bits.
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Handshake and status outputs.
  // ---------------------------------------------------------------------------------------
  assign accept = rx_valid_q && rx_ready;

  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = bad_frame;
    overrun_d   = 1'b0;

    if (accept) begin
      rx_valid_d = 1'b0;
    end

    if (good_frame) begin
      // An accept in the same clk frees the holding register for the new byte.
      if (!rx_valid_q || accept) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the serial link: recovers 8N1-style frames from the asynchronous `rx` line and presents each byte on a valid/ready handshake.
- Single clock domain. Derives its own oversample enable tick from the system clock using the same INITIAL_CLOCK/BAUD/OVERSAMPLE_TIME parameter set as the link's baud generator.
- Sits between the pad-side `rx` input and the byte consumer (FIFO or control logic).

Parameters:
- INITIAL_CLOCK, 100000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate in bit/s.
- OVERSAMPLE_TIME, 8, sample ticks per bit period; even, >= 4.
- DATA_BITS, 8, data bits per frame (5..9), sent LSB first; no parity; 1 stop bit.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous reset, active-low; asserting it (0) resets all state immediately; release is synchronous to clk.
- rx  input  1  serial line, idle high; asynchronous to clk.
- rx_ready  input  1  consumer accepts byte when rx_valid && rx_ready.
- rx_data  output  DATA_BITS  received byte; stable while rx_valid = 1.
- rx_valid  output  1  byte available; held until accepted.
- frame_err  output  1  1-cycle pulse: stop bit sampled low.
- overrun  output  1  1-cycle pulse: frame completed while previous byte still unaccepted.

Behaviour:
- Reset values: rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, state = IDLE, all counters = 0, synchronizer flops = 1.
- Input synchronizer: 2-FF chain on `rx` gives rx_s. All decisions use rx_s, which adds 2 clk latency.
- Tick generator:
  - DIV = INITIAL_CLOCK / (BAUD * OVERSAMPLE_TIME) - 1, integer division.
  - Counter runs 0..DIV, free-running from reset.
  - `tick` is a 1-clk pulse when the counter equals DIV, then the counter wraps to 0.
  - DIV = 0 means tick every clk.
- os_cnt counts ticks within a bit. bit_cnt counts data bits received. All state moves happen only on tick cycles, except the WAIT_IDLE exit and the handshake logic, which run on every clk.
- IDLE:
  - On tick with rx_s = 0: go to START, os_cnt = 0.
- START:
  - On tick: os_cnt++.
  - When os_cnt reaches OVERSAMPLE_TIME/2 - 1 (mid start bit):
    - rx_s = 1: glitch; return to IDLE with no outputs.
    - rx_s = 0: go to DATA, os_cnt = 0, bit_cnt = 0.
- DATA:
  - On tick: os_cnt++.
  - At os_cnt = OVERSAMPLE_TIME - 1 (mid data bit): shift rx_s into the MSB of the shift register (LSB-first frame), os_cnt = 0, bit_cnt++.
  - After DATA_BITS samples: go to STOP.
- STOP:
  - At os_cnt = OVERSAMPLE_TIME - 1 (mid stop bit), sample rx_s.
  - rx_s = 1:
    - Frame good; return to IDLE.
    - If rx_valid = 0, or rx_valid && rx_ready in this same clk: load rx_data; rx_valid = 1 next clk.
    - Otherwise: overrun pulse, new byte discarded, rx_data and rx_valid unchanged.
  - rx_s = 0: frame_err pulse; byte discarded; go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s = 1 (checked every clk), then go to IDLE. A held break therefore produces exactly one frame_err.
- Handshake:
  - rx_valid && rx_ready in a clk clears rx_valid next clk, unless a good frame completes in that same clk. In that case rx_valid stays 1, rx_data takes the new byte, and there is no overrun.
- Latency: rx_valid rises 1 clk after the tick on which the stop bit is sampled.
- rx_ready while rx_valid = 0 is ignored.
- frame_err and overrun are mutually exclusive per frame and never assert outside the stop-sample clk.
- Reset mid-frame: everything returns to reset values at once; the partial byte is lost.

Test Plan:
Bench parameters for all cases: INITIAL_CLOCK = 1600000, BAUD = 100000, OVERSAMPLE_TIME = 8. This gives DIV = 1, a tick every 2 clk, and a bit period of 16 clk.
- Send 0xA5 framed (start 0, bits 1,0,1,0,0,1,0,1, stop 1), rx_ready = 0 -> rx_data = 0xA5, rx_valid = 1 and held; no frame_err or overrun.
- Back-to-back 0x3C then 0xC3, rx_ready pulsed 1 clk after each rx_valid -> two handshakes with 0x3C then 0xC3; overrun never asserts.
- Send 0x11 and leave it unaccepted, then send 0x22 -> overrun pulses exactly 1 clk at 0x22's stop sample; rx_data stays 0x11; rx_valid stays 1.
- Send 0x55 with the stop bit driven 0, then line held low for 40 clk before returning high -> one frame_err pulse; rx_valid stays 0; the next 0x7E frame is received correctly.
- Low glitch of 4 clk on an idle line -> no state leaves IDLE for longer than the start check; no outputs. Then assert rst = 0 during bit 3 of a frame -> all outputs 0 immediately; a subsequent clean 0x81 is received.
